ext_light_ctrl: RTL and testbench

//  Sequences the exterior lights from the 8-bit luminosity sensor. Uses hysteresis thresholds
//  and an N-consecutive-sample persistence filter so passing shadows or headlights do not

---
 rtl/ext_light_ctrl.sv | 124 ++++++++++++
 tb/tb_ext_light_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_light_ctrl.sv
// Exterior light sequencer: hysteresis + persistence filter on luminosity samples,
// manual override, saturating soft-start/soft-stop dimming ramp and PWM output.
module ext_light_ctrl #(
    parameter int ON_TH     = 40,
    parameter int OFF_TH    = 60,
    parameter int HOLD      = 4,
    parameter int RAMP_STEP = 16
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [7:0] Lum_sen,
    input  logic       Sample_en,
    input  logic       Man_on,
    input  logic       Man_off,
    output logic       Ext_light,
    output logic [7:0] Dim_level,
    output logic       Pwm_out,
    output logic [1:0] State
);

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_PEND_ON  = 2'd1,
        ST_ON       = 2'd2,
        ST_PEND_OFF = 2'd3
    } state_t;

    localparam logic [7:0] ON_TH_B  = 8'(ON_TH);
    localparam logic [7:0] OFF_TH_B = 8'(OFF_TH);
    localparam logic [3:0] HOLD_B   = 4'(HOLD);
    localparam logic [8:0] STEP_B   = 9'(RAMP_STEP);

    state_t     state;
    logic [3:0] hold_cnt;
    logic [3:0] hold_next;
    logic [7:0] pwm_cnt;
    logic       is_dark;
    logic       is_bright;
    logic [8:0] dim_up;
    logic [8:0] dim_dn;

    assign is_dark   = Lum_sen < ON_TH_B;
    assign is_bright = Lum_sen > OFF_TH_B;
    assign hold_next = hold_cnt + 4'd1;

    assign Ext_light = (state == ST_ON) || (state == ST_PEND_OFF);
    assign State     = state;

    // Overrides beat the sample strobe; the filter only sees samples when both are low.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_OFF;
            hold_cnt <= 4'd0;
        end else if (Man_on) begin
            state    <= ST_ON;
            hold_cnt <= 4'd0;
        end else if (Man_off) begin
            state    <= ST_OFF;
            hold_cnt <= 4'd0;
        end else if (Sample_en) begin
            case (state)
                ST_OFF: begin
                    if (is_dark) begin
                        state    <= ST_PEND_ON;
                        hold_cnt <= 4'd1;
                    end
                end
                ST_PEND_ON: begin
                    if (!is_dark) begin
                        state    <= ST_OFF;
                        hold_cnt <= 4'd0;
                    end else if (hold_next == HOLD_B) begin
                        state    <= ST_ON;
                        hold_cnt <= 4'd0;
                    end else begin
                        hold_cnt <= hold_next;
                    end
                end
                ST_ON: begin
                    if (is_bright) begin
                        state    <= ST_PEND_OFF;
                        hold_cnt <= 4'd1;
                    end
                end
                ST_PEND_OFF: begin
                    if (!is_bright) begin
                        state    <= ST_ON;
                        hold_cnt <= 4'd0;
                    end else if (hold_next == HOLD_B) begin
                        state    <= ST_OFF;
                        hold_cnt <= 4'd0;
                    end else begin
                        hold_cnt <= hold_next;
                    end
                end
                default: begin
                    state    <= ST_OFF;
                    hold_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Ninth bit flags overflow on the way up and borrow on the way down.
    assign dim_up = {1'b0, Dim_level} + STEP_B;
    assign dim_dn = {1'b0, Dim_level} - STEP_B;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            Dim_level <= 8'd0;
            pwm_cnt   <= 8'd0;
            Pwm_out   <= 1'b0;
        end else begin
            if (Ext_light) begin
                Dim_level <= dim_up[8] ? 8'hFF : dim_up[7:0];
            end else begin
                Dim_level <= dim_dn[8] ? 8'h00 : dim_dn[7:0];
            end
            pwm_cnt <= pwm_cnt + 8'd1;
            Pwm_out <= (pwm_cnt < Dim_level) || (Dim_level == 8'hFF);
        end
    end

endmodule

// File: tb/tb_ext_light_ctrl.sv
// Self-checking bench for ext_light_ctrl: directed scenarios plus randomized traffic,
// all compared against a streak-counting behavioural model of the light controller.
module tb_ext_light_ctrl;

    logic       CLK;
    logic       Reset;
    logic [7:0] Lum_sen;
    logic       Sample_en;
    logic       Man_on;
    logic       Man_off;
    logic       Ext_light;
    logic [7:0] Dim_level;
    logic       Pwm_out;
    logic [1:0] State;

    int checks = 0;
    int errors = 0;

    // Model: light request plus length of the current run of qualifying samples.
    bit m_light;
    int m_streak;
    int m_dim;
    int m_cnt;
    bit m_pwm;

    ext_light_ctrl dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .Lum_sen   (Lum_sen),
        .Sample_en (Sample_en),
        .Man_on    (Man_on),
        .Man_off   (Man_off),
        .Ext_light (Ext_light),
        .Dim_level (Dim_level),
        .Pwm_out   (Pwm_out),
        .State     (State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [11:0] model_vec();
        logic [1:0] s;
        if (m_light) s = (m_streak != 0) ? 2'd3 : 2'd2;
        else         s = (m_streak != 0) ? 2'd1 : 2'd0;
        return {s, m_light, m_dim[7:0], m_pwm};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {State, Ext_light, Dim_level, Pwm_out};
    endfunction

    task automatic model_reset();
        m_light = 0; m_streak = 0; m_dim = 0; m_cnt = 0; m_pwm = 0;
    endtask

    // One clock edge: derive the model's next values from the pre-edge inputs, then advance.
    task automatic step();
        bit n_light;
        int n_streak;
        int n_dim;
        bit n_pwm;
        bit qual;
        n_pwm    = (m_cnt < m_dim) || (m_dim == 255);
        n_dim    = m_light ? ((m_dim + 16 > 255) ? 255 : m_dim + 16)
                           : ((m_dim < 16) ? 0 : m_dim - 16);
        n_light  = m_light;
        n_streak = m_streak;
        if (Man_on) begin
            n_light = 1; n_streak = 0;
        end else if (Man_off) begin
            n_light = 0; n_streak = 0;
        end else if (Sample_en) begin
            qual = m_light ? (int'(Lum_sen) > 60) : (int'(Lum_sen) < 40);
            if (qual) begin
                n_streak++;
                if (n_streak == 4) begin
                    n_light  = !n_light;
                    n_streak = 0;
                end
            end else begin
                n_streak = 0;
            end
        end
        @(posedge CLK);
        m_light = n_light; m_streak = n_streak; m_dim = n_dim; m_pwm = n_pwm;
        m_cnt = (m_cnt + 1) % 256;
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            Lum_sen   = 8'($urandom_range(0, 255));
            Sample_en = 1'($urandom_range(0, 1));
            Man_on    = 1'($urandom_range(0, 1));
            Man_off   = 1'($urandom_range(0, 1));
            @(posedge CLK);
            #1;
            checks++;
            if (dut_vec() !== 12'h000) begin
                errors++;
                $display("[TB] FAIL reset_hold: got %h expected %h", dut_vec(), 12'h000);
            end
        end
        Lum_sen = 8'd100; Sample_en = 1'b0; Man_on = 1'b0; Man_off = 1'b0;
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (State !== 2'd0 || dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL reset_release: got %h expected %h", dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_dark_filter();
        int exp_dim;
        int highs;
        for (int i = 0; i < 4; i++) begin
            Lum_sen = 8'd20; Sample_en = 1'b1;
            step();
            Sample_en = 1'b0;
            checks++;
            if (Ext_light !== (i == 3) || dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL dark_strobe%0d: got %h expected %h light %0d",
                         i, dut_vec(), model_vec(), (i == 3));
            end
            if (i < 3) step();
        end
        for (int k = 1; k <= 17; k++) begin
            step();
            exp_dim = (k * 16 > 255) ? 255 : k * 16;
            checks++;
            if (Dim_level !== 8'(exp_dim) || dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL ramp_up%0d: got dim %0d expected %0d (vec %h vs %h)",
                         k, Dim_level, exp_dim, dut_vec(), model_vec());
            end
        end
        highs = 0;
        for (int k = 0; k < 260; k++) begin
            step();
            if (Pwm_out === 1'b1 && Dim_level === 8'hFF) highs++;
        end
        checks++;
        if (highs !== 260) begin
            errors++;
            $display("[TB] FAIL full_on_pwm: got %0d high cycles expected %0d", highs, 260);
        end
    endtask

    task automatic test_glitch();
        logic [7:0] lums [6];
        logic [1:0] exps [6];
        lums = '{8'd90, 8'd90, 8'd50, 8'd90, 8'd60, 8'd61};
        exps = '{2'd3, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3};
        for (int i = 0; i < 6; i++) begin
            Lum_sen = lums[i]; Sample_en = 1'b1;
            step();
            Sample_en = 1'b0;
            checks++;
            if (State !== exps[i] || Ext_light !== 1'b1 || dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL glitch%0d: got state %0d light %0d expected state %0d light 1",
                         i, State, Ext_light, exps[i]);
            end
        end
    endtask

    task automatic test_override();
        logic [1:0] exps [4];
        exps = '{2'd3, 2'd3, 2'd3, 2'd0};
        Man_off = 1'b1;
        step();
        checks++;
        if (State !== 2'd0 || dut_vec() !== model_vec()) begin
            errors++;
            $display("[TB] FAIL man_off: got %h expected %h", dut_vec(), model_vec());
        end
        Man_off = 1'b0; Man_on = 1'b1; Lum_sen = 8'd200; Sample_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (State !== 2'd2 || dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL man_on%0d: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        Man_off = 1'b1;
        step();
        checks++;
        if (State !== 2'd2 || dut_vec() !== model_vec()) begin
            errors++;
            $display("[TB] FAIL man_both: got %h expected %h", dut_vec(), model_vec());
        end
        Man_on = 1'b0; Man_off = 1'b0; Sample_en = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            Lum_sen = 8'd200; Sample_en = 1'b1;
            step();
            Sample_en = 1'b0;
            checks++;
            if (State !== exps[i] || dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL bright_strobe%0d: got state %0d expected %0d",
                         i, State, exps[i]);
            end
            step();
        end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL ramp_down%0d: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        checks++;
        if (Dim_level !== 8'd0) begin
            errors++;
            $display("[TB] FAIL ramp_down_final: got %0d expected 0", Dim_level);
        end
    endtask

    task automatic test_reversal();
        Man_on = 1'b1;
        step();
        Man_on = 1'b0;
        for (int i = 0; i < 7; i++) step();
        checks++;
        if (Dim_level !== 8'd112 || dut_vec() !== model_vec()) begin
            errors++;
            $display("[TB] FAIL pre_reverse: got dim %0d expected 112", Dim_level);
        end
        Man_off = 1'b1;
        step();
        Man_off = 1'b0;
        checks++;
        if (Dim_level !== 8'd128 || State !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reverse_edge: got dim %0d state %0d expected 128 0", Dim_level, State);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (Dim_level !== 8'(128 - 16 * i) || dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL reverse%0d: got dim %0d expected %0d", i, Dim_level, 128 - 16 * i);
            end
        end
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 12'h000) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h expected %h", dut_vec(), 12'h000);
        end
        model_reset();
        @(posedge CLK);
        #1;
        Reset = 1'b1;
    endtask

    task automatic test_pwm();
        int highs;
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (Pwm_out === 1'b1) highs++;
        end
        checks++;
        if (highs !== 0) begin
            errors++;
            $display("[TB] FAIL pwm_zero: got %0d high cycles expected 0", highs);
        end
        Man_on = 1'b1;
        step();
        Man_on = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL pwm_ramp%0d: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (Pwm_out === 1'b1) highs++;
        end
        checks++;
        if (highs !== 256) begin
            errors++;
            $display("[TB] FAIL pwm_full: got %0d high cycles expected 256", highs);
        end
    endtask

    task automatic test_random();
        logic [7:0] edge_vals [6];
        int r;
        edge_vals = '{8'd39, 8'd40, 8'd41, 8'd59, 8'd60, 8'd61};
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 3)      Lum_sen = 8'($urandom_range(0, 39));
            else if (r < 6) Lum_sen = 8'($urandom_range(61, 255));
            else if (r < 8) Lum_sen = edge_vals[$urandom_range(0, 5)];
            else            Lum_sen = 8'($urandom_range(0, 255));
            Sample_en = 1'($urandom_range(0, 1));
            Man_on    = ($urandom_range(0, 59) == 0);
            Man_off   = ($urandom_range(0, 59) == 0);
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("[TB] FAIL random%0d: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        Man_on = 1'b0; Man_off = 1'b0; Sample_en = 1'b0;
    endtask

    initial begin
        Reset = 1'b0; Lum_sen = 8'd0; Sample_en = 1'b0; Man_on = 1'b0; Man_off = 1'b0;
        model_reset();
        test_reset();
        test_dark_filter();
        test_glitch();
        test_override();
        test_reversal();
        test_pwm();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
